// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolver result path.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } coll_state_t;

  localparam int DEF_KERN_DIM = 3;
  localparam int DEF_WIDTH    = 28;
  localparam int DEF_HEIGHT   = 28;

  localparam int OUT_W = DEF_WIDTH - DEF_KERN_DIM + 1;
  localparam int OUT_H = DEF_HEIGHT - DEF_KERN_DIM + 1;
  localparam int OUT_N = OUT_W * OUT_H;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster col/row position counter: advances one pixel per enable, wraps col at WIDTH-1 and row at the last pixel.
// Single-cycle update; clear has priority over advance.
module conv_pos_counter #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      adv,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      last
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic col_last;

  assign col_last = (col == COL_MAX);
  assign last     = col_last && (row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_result_collector.sv
// Drops edge-overhang convolver results, emits the rest with row-major addresses; 1-cycle latency, single output register.
// in_ready falls while the held output is stalled; COLLECT_RELU_EN clamps negative kept results to zero.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int KERN_DIM = DEF_KERN_DIM,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int DATA_BW  = 16,
  parameter int ADDR_BW  = $clog2(OUT_N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_BW-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_BW-1:0] out_data,
  output logic [ADDR_BW-1:0] out_addr,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] KEEP_COL = CW'(KERN_DIM - 1);
  localparam logic [RW-1:0] KEEP_ROW = RW'(KERN_DIM - 1);

  coll_state_t        state_q, state_d;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               pos_last;
  logic               clear;
  logic               done_d;
  logic               in_hs;
  logic               keep;
  logic               load;
  logic               out_hs;
  logic [ADDR_BW-1:0] addr_q;
  logic [DATA_BW-1:0] load_data;

  assign in_hs  = in_valid && in_ready;
  assign keep   = (col >= KEEP_COL) && (row >= KEEP_ROW);
  assign load   = in_hs && keep;
  assign out_hs = out_valid && out_ready;

`ifdef COLLECT_RELU_EN
  assign load_data = in_data[DATA_BW-1] ? '0 : in_data;
`else
  assign load_data = in_data;
`endif

  conv_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .adv   (in_hs),
    .col   (col),
    .row   (row),
    .last  (pos_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = COLLECT;
          clear   = 1'b1;
        end
      end
      COLLECT: begin
        // Output register frees up this cycle when it is empty or being drained.
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready) && pos_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!out_valid || out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      addr_q    <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_d;
      if (clear)     addr_q <= '0;
      else if (load) addr_q <= addr_q + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_addr  <= addr_q;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
